// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at launch. The result is committed to HI/LO after a fixed latency.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    count;

  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               signed_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // One-shot datapath working on the latched operands; it only matters at commit.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    if (op_q == OP_MULT) begin
      a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a_q};
      b_ext = {{WIDTH{1'b0}}, b_q};
    end
    product = a_ext * b_ext;

    // Signed divide via magnitudes; most-negative/-1 falls out as most-negative, remainder 0.
    signed_div = (op_q == OP_DIV);
    a_neg      = signed_div & a_q[WIDTH-1];
    b_neg      = signed_div & b_q[WIDTH-1];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    q_mag      = '0;
    r_mag      = a_mag;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
    if (b_q == '0) begin
      quot = '1;
      rem  = a_q;
    end

    if (op_q[1]) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = product[2*WIDTH-1:WIDTH];
      res_lo = product[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      count <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_t'(op);
            a_q   <= input1;
            b_q   <= input2;
            count <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            busy  <= 1'b1;
            state <= BUSY;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= wdata;
            else          lo <= wdata;
          end
        end
        BUSY: begin
          // Counter reaches zero on this edge: commit and return to idle.
          if (count == CW'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] input1, input2;
  logic         hilo_we;
  logic         hilo_sel;
  logic [W-1:0] wdata;
  logic         busy;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  mult_div_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .input1(input1), .input2(input2),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  task automatic model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    h = '0;
    l = '0;
    case (mop)
      2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == '0) begin
          l = '1;
          h = a;
        end else begin
          if (mop == 2'd2) begin q = sa / sb; r = sa % sb; end
          else             begin q = ua / ub; r = ua % ub; end
          l = q[31:0];
          h = r[31:0];
        end
      end
    endcase
  endtask

  // Called right after a negedge; returns right after the negedge where busy is seen low.
  task automatic do_op(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit with_write, input bit poke);
    logic [W-1:0] nh, nl;
    int cnt;
    int n;
    n        = mop[1] ? DC : MC;
    start    = 1'b1;
    op       = mop;
    input1   = a;
    input2   = b;
    hilo_we  = with_write;
    hilo_sel = 1'($urandom_range(0, 1));
    wdata    = $urandom;
    @(negedge clk);
    start   = 1'b0;
    hilo_we = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1'b1));
    check("hi_hold", 64'(hi), 64'(exp_hi));
    check("lo_hold", 64'(lo), 64'(exp_lo));
    model(mop, a, b, nh, nl);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (poke && cnt == 1) begin
        start  = 1'b1;
        op     = ~mop;
        input1 = ~a;
        input2 = b + 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    if (cnt >= 100) check("busy_timeout", 64'(cnt), 64'(n));
    check("busy_cycles", 64'(cnt), 64'(n));
    check("hi_result", 64'(hi), 64'(nh));
    check("lo_result", 64'(lo), 64'(nl));
    exp_hi = nh;
    exp_lo = nl;
  endtask

  task automatic hilo_write(input logic sel, input logic [W-1:0] d);
    hilo_we  = 1'b1;
    hilo_sel = sel;
    wdata    = d;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) exp_hi = d;
    else     exp_lo = d;
    check("mt_busy", 64'(busy), 64'(1'b0));
    check("mt_hi", 64'(hi), 64'(exp_hi));
    check("mt_lo", 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    op       = 2'd0;
    input1   = '0;
    input2   = '0;
    hilo_we  = 1'b0;
    hilo_sel = 1'b0;
    wdata    = '0;
    #1;
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    check("t1_hi", 64'(hi), 64'h1);
    check("t1_lo", 64'(lo), 64'hFFFF_FFFE);
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("t2_mult_hi", 64'(hi), 64'h0);
    check("t2_mult_lo", 64'(lo), 64'h1);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("t2_multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2_multu_lo", 64'(lo), 64'h1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("t3_div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("t3_div_hi", 64'(hi), 64'hFFFF_FFFF);
    do_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("t3_divu_lo", 64'(lo), 64'd3);
    check("t3_divu_hi", 64'(hi), 64'd1);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("t4_ovf_lo", 64'(lo), 64'h8000_0000);
    check("t4_ovf_hi", 64'(hi), 64'h0);
    do_op(2'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    check("t4_dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("t4_dz_hi", 64'(hi), 64'd5);
    @(negedge clk);
    hilo_write(1'b0, 32'h1234);
    hilo_write(1'b1, 32'hABCD);
    check("t5_lo", 64'(lo), 64'h1234);
    check("t5_hi", 64'(hi), 64'hABCD);
    do_op(2'd0, 32'd6, 32'hFFFF_FFFE, 1'b1, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a divide
    start  = 1'b1;
    op     = 2'd2;
    input1 = 32'd1000;
    input2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_busy_pre", 64'(busy), 64'(1'b1));
    #2 reset = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'(1'b0));
    check("t6_hi", 64'(hi), 64'(0));
    check("t6_lo", 64'(lo), 64'(0));
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(2'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    check("t6_mult_hi", 64'(hi), 64'd0);
    check("t6_mult_lo", 64'(lo), 64'd12);

    // Randomized traffic, back-to-back where the draw allows
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0)
        hilo_write(1'($urandom_range(0, 1)), $urandom);
      else
        do_op(2'($urandom_range(0, 3)), pick(), pick(),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
